mmss_timer_display: RTL



---
 rtl/mmss_timer_display_if.sv | 58 +++++
 rtl/mmss_timer_display.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmss_timer_display_if.sv
// Command/display bundle for the mm:ss timer core.
// Commands flow in from the button logic, digits and flags flow out.
interface mmss_timer_display_if;
    logic        start;
    logic        stop;
    logic        clear;
    logic        load;
    logic [11:0] load_time;
    logic        mode_down;
    logic        lap;
    logic        show_lap;
    logic [6:0]  seg3;
    logic [6:0]  seg2;
    logic [6:0]  seg1;
    logic [6:0]  seg0;
    logic [15:0] time_bcd;
    logic        running;
    logic        busy;
    logic        expired;

    modport master (
        output start,
        output stop,
        output clear,
        output load,
        output load_time,
        output mode_down,
        output lap,
        output show_lap,
        input  seg3,
        input  seg2,
        input  seg1,
        input  seg0,
        input  time_bcd,
        input  running,
        input  busy,
        input  expired
    );

    modport slave (
        input  start,
        input  stop,
        input  clear,
        input  load,
        input  load_time,
        input  mode_down,
        input  lap,
        input  show_lap,
        output seg3,
        output seg2,
        output seg1,
        output seg0,
        output time_bcd,
        output running,
        output busy,
        output expired
    );
endinterface

// File: rtl/mmss_timer_display.sv
// BCD mm:ss stopwatch/countdown with binary load, lap register
// and four 7-segment digit decoders.
module mmss_timer_display #(
    parameter int TICKS_PER_SEC = 100,
    parameter int MAX_MIN       = 59,
    parameter bit LEAD_BLANK    = 1'b1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    mmss_timer_display_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [9:0]  PRESC_LAST = 10'(TICKS_PER_SEC - 1);
    localparam logic [5:0]  MIN_CAP    = 6'(MAX_MIN);
    localparam logic [15:0] TERM_UP    = {
        4'(MAX_MIN / 10),
        4'(MAX_MIN % 10),
        4'd5,
        4'd9
    };
    localparam logic [15:0] TERM_DOWN  = 16'h0000;

    state_t      state;
    state_t      state_n;
    logic [15:0] time_q;
    logic [15:0] time_n;
    logic [15:0] lap_q;
    logic [9:0]  presc_q;
    logic [9:0]  presc_n;
    logic        dir_q;
    logic        dir_n;
    logic [5:0]  rem_m_q;
    logic [5:0]  rem_m_n;
    logic [5:0]  rem_s_q;
    logic [5:0]  rem_s_n;
    logic [3:0]  ten_m_q;
    logic [3:0]  ten_m_n;
    logic [3:0]  ten_s_q;
    logic [3:0]  ten_s_n;

    logic [5:0]  min_raw;
    logic [5:0]  sec_raw;
    logic [5:0]  min_clamp;
    logic [5:0]  sec_clamp;
    logic [15:0] step_val;
    logic [15:0] start_term;
    logic [15:0] shown;

    logic        cmd_clear;
    logic        cmd_load;
    logic        cmd_stop;
    logic        cmd_start;

    function automatic logic [15:0] step_up(input logic [15:0] t);
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
        {m1, m0, s1, s0} = t;
        if (s0 != 4'd9) begin
            s0 = s0 + 4'd1;
        end else begin
            s0 = 4'd0;
            if (s1 != 4'd5) begin
                s1 = s1 + 4'd1;
            end else begin
                s1 = 4'd0;
                if (m0 != 4'd9) begin
                    m0 = m0 + 4'd1;
                end else begin
                    m0 = 4'd0;
                    m1 = m1 + 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    function automatic logic [15:0] step_down(input logic [15:0] t);
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
        {m1, m0, s1, s0} = t;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign min_raw   = bus.load_time[11:6];
    assign sec_raw   = bus.load_time[5:0];
    assign min_clamp = (min_raw > MIN_CAP) ? MIN_CAP : min_raw;
    assign sec_clamp = (sec_raw > 6'd59) ? 6'd59 : sec_raw;

    assign step_val   = dir_q ? step_down(time_q) : step_up(time_q);
    assign start_term = bus.mode_down ? TERM_DOWN : TERM_UP;

    // Only the highest-priority asserted command may act in a cycle.
    assign cmd_clear = bus.clear;
    assign cmd_load  = !bus.clear && bus.load && (state != LOAD);
    assign cmd_stop  = !bus.clear && !bus.load && bus.stop
                       && (state == RUN);
    assign cmd_start = !bus.clear && !bus.load && !bus.stop
                       && bus.start && (state == IDLE);

    always_comb begin
        state_n = state;
        time_n  = time_q;
        presc_n = presc_q;
        dir_n   = dir_q;
        rem_m_n = rem_m_q;
        rem_s_n = rem_s_q;
        ten_m_n = ten_m_q;
        ten_s_n = ten_s_q;
        if (cmd_clear) begin
            state_n = IDLE;
            time_n  = 16'h0000;
            presc_n = 10'd0;
        end else if (cmd_load) begin
            rem_m_n = min_clamp;
            rem_s_n = sec_clamp;
            ten_m_n = 4'd0;
            ten_s_n = 4'd0;
            presc_n = 10'd0;
            state_n = LOAD;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_start) begin
                        dir_n   = bus.mode_down;
                        state_n = (time_q == start_term) ? DONE : RUN;
                    end
                end
                LOAD: begin
                    if (rem_m_q < 6'd10 && rem_s_q < 6'd10) begin
                        time_n  = {ten_m_q, rem_m_q[3:0],
                                   ten_s_q, rem_s_q[3:0]};
                        state_n = IDLE;
                    end else begin
                        if (rem_m_q >= 6'd10) begin
                            rem_m_n = rem_m_q - 6'd10;
                            ten_m_n = ten_m_q + 4'd1;
                        end
                        if (rem_s_q >= 6'd10) begin
                            rem_s_n = rem_s_q - 6'd10;
                            ten_s_n = ten_s_q + 4'd1;
                        end
                    end
                end
                RUN: begin
                    if (cmd_stop) begin
                        state_n = IDLE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_n = 10'd0;
                        time_n  = step_val;
                        if (step_val == (dir_q ? TERM_DOWN : TERM_UP)) begin
                            state_n = DONE;
                        end
                    end else begin
                        presc_n = presc_q + 10'd1;
                    end
                end
                DONE: begin
                    state_n = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= IDLE;
            time_q  <= 16'h0000;
            lap_q   <= 16'h0000;
            presc_q <= 10'd0;
            dir_q   <= 1'b0;
            rem_m_q <= 6'd0;
            rem_s_q <= 6'd0;
            ten_m_q <= 4'd0;
            ten_s_q <= 4'd0;
        end else begin
            state   <= state_n;
            time_q  <= time_n;
            presc_q <= presc_n;
            dir_q   <= dir_n;
            rem_m_q <= rem_m_n;
            rem_s_q <= rem_s_n;
            ten_m_q <= ten_m_n;
            ten_s_q <= ten_s_n;
            // Captures the pre-step value when it lands on a step edge.
            if (bus.lap) begin
                lap_q <= time_q;
            end
        end
    end

    assign shown = bus.show_lap ? lap_q : time_q;

    assign bus.seg0 = seg_decode(shown[3:0]);
    assign bus.seg1 = seg_decode(shown[7:4]);
    assign bus.seg2 = seg_decode(shown[11:8]);
    assign bus.seg3 = (LEAD_BLANK && shown[15:12] == 4'd0)
                      ? 7'b0000000 : seg_decode(shown[15:12]);

    assign bus.time_bcd = time_q;
    assign bus.running  = (state == RUN);
    assign bus.busy     = (state == LOAD);
    assign bus.expired  = (state == DONE);

endmodule
